// File: rtl/multicycle_adder_pkg.sv
// Shared definitions for the multi-cycle adder.
//   state_t   : FSM state encoding (IDLE, RUN).
//   idx_width : width of the chunk-index counter for N compute cycles,
//               ceil(log2(N)) and never less than 1 bit.
package multicycle_adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ripple_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
// Ports:
//   a_c, b_c : CHUNK-bit operand slices
//   c_in     : carry into bit 0
//   s_c      : CHUNK-bit sum slice
//   c_out    : carry out of bit CHUNK-1
module ripple_chunk #(
    parameter int CHUNK = 1
) (
    input  logic [CHUNK-1:0] a_c,
    input  logic [CHUNK-1:0] b_c,
    input  logic             c_in,
    output logic [CHUNK-1:0] s_c,
    output logic             c_out
);

    logic [CHUNK:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s_c[i]  = a_c[i] ^ b_c[i] ^ c[i];
        assign c[i+1]  = (a_c[i] & b_c[i]) | (c[i] & (a_c[i] ^ b_c[i]));
    end

    assign c_out = c[CHUNK];

endmodule

// File: rtl/multicycle_adder.sv
// Multi-cycle adder: sum = a + b + cin, computed CHUNK bits per clock over
// N = WIDTH/CHUNK cycles, with a two's-complement overflow flag.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   start, a, b, cin: request and operands, sampled only while idle
//   busy            : high while an operation is in progress
//   done            : one-cycle pulse, results valid in the same cycle
//   sum, cout, ovf  : result of the last completed operation (held)
//
// Handshake: start is accepted on any rising edge where the FSM is IDLE
// (busy low, or the cycle where done is high). busy rises on the accepting
// edge; N edges later done pulses for one cycle and busy falls. start while
// busy is ignored, never queued. sum/cout/ovf only change with done.
module multicycle_adder
    import multicycle_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("multicycle_adder: CHUNK must be >= 1 and divide WIDTH");
    end

    localparam int            N    = WIDTH / CHUNK;
    localparam int            IW   = idx_width(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    // Current FSM state; kept as a named signal so checkers can bind to it.
    state_t             state;
    logic [IW-1:0]      idx;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               carry;
    logic [WIDTH-1:0]   work_sum;

    logic [WIDTH-1:0]   work_next;
    logic [CHUNK-1:0]   a_c;
    logic [CHUNK-1:0]   b_c;
    logic [CHUNK-1:0]   s_c;
    logic               c_out;
    int                 base;

    // Select chunk idx of each operand and merge the new chunk result into
    // the working sum, so the final cycle can publish it directly.
    always_comb begin
        base      = int'(idx) * CHUNK;
        a_c       = op_a[base +: CHUNK];
        b_c       = op_b[base +: CHUNK];
        work_next = work_sum;
        work_next[base +: CHUNK] = s_c;
    end

    ripple_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_c   (a_c),
        .b_c   (b_c),
        .c_in  (carry),
        .s_c   (s_c),
        .c_out (c_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            work_sum <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a     <= a;
                        op_b     <= b;
                        carry    <= cin;
                        idx      <= '0;
                        work_sum <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    work_sum <= work_next;
                    carry    <= c_out;
                    if (idx == LAST) begin
                        sum   <= work_next;
                        cout  <= c_out;
                        // a^b^sum at the MSB recovers the carry into the MSB.
                        ovf   <= op_a[WIDTH-1] ^ op_b[WIDTH-1] ^ work_next[WIDTH-1] ^ c_out;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        idx   <= '0;
                        state <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/multicycle_adder.md
# multicycle_adder

Parametrised multi-cycle adder that adds two WIDTH-bit operands plus a carry-in, CHUNK bits per clock, using a ripple chunk of full-adder cells. It is the clocked successor of the combinational full-adder cell: same arithmetic, but generalised in width, with selectable bits-per-cycle, a start/busy/done handshake and a signed-overflow flag. It sits between an operand source (register file or test sequencer) and any consumer that samples results on `done`.

## Interface
- `WIDTH`, 8, operand and sum width in bits; must be ≥ 1.
- `CHUNK`, 1, bits processed per cycle; must divide WIDTH. Elaboration fails otherwise. N = WIDTH/CHUNK is the number of compute cycles.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request; sampled only while idle.
- `a`  in  WIDTH  operand A; sampled with `start`.
- `b`  in  WIDTH  operand B; sampled with `start`.
- `cin`  in  1  carry-in; sampled with `start`.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; results valid in the same cycle.
- `sum`  out  WIDTH  result of the last completed operation.
- `cout`  out  1  carry out of bit WIDTH-1.
- `ovf`  out  1  two's-complement overflow of the last operation.

## Operation
- States: IDLE, RUN. Reset → IDLE, with `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0, chunk index=0.
- IDLE and `start`=1: latch a, b, cin into internal operand and carry registers, clear the chunk index to 0, go to RUN, and set `busy`=1.
- RUN: each cycle adds chunk k (bits k·CHUNK … k·CHUNK+CHUNK-1) of both operands plus the carry register.
  - Write the chunk result into the working sum register and update the carry register.
  - Increment k.
- On the cycle processing k=N-1:
  - Copy the working sum to `sum`; the final carry goes to `cout`.
  - `ovf` = a[W-1] ^ b[W-1] ^ sum[W-1] ^ cout, i.e. carry-in of the MSB xor carry-out.
  - Pulse `done`, clear `busy`, return to IDLE.
- `sum`, `cout` and `ovf` change only on completion. They hold the previous result throughout RUN and indefinitely in IDLE.
- `start` while busy is ignored; it is neither queued nor an error.
- `start` in the same cycle `done` is high is accepted, because the state is already IDLE.
- Reset asserted mid-operation aborts the operation: no `done` pulse, and all outputs return to their reset values at that edge.
- Arithmetic is unsigned modulo 2^WIDTH with carry out. `ovf` is informational; the sum is not saturated.

## Timing
- `start` sampled at edge E0 → `busy` high from E0. `done`, `sum`, `cout` and `ovf` are updated at edge EN; latency is N cycles.
- `done` is high for exactly one cycle, the cycle after EN.
- Maximum throughput is one operation per N+1 cycles. This occurs with `start` held high: done pulses every N+1 cycles.
- CHUNK=WIDTH gives N=1: a single-cycle registered adder.
- All outputs are registered; no combinational path from input to output.

## Structure
- Shared package holds:
  - the state encoding constants (IDLE, RUN);
  - a helper function computing the chunk-index width, ceil(log2(N)) with a minimum of 1.
- One sub-module, `ripple_chunk`: combinational CHUNK-bit ripple adder built from full-adder cells. Inputs a_c, b_c, c_in; outputs s_c, c_out. Instantiated once; the datapath muxes chunk k into it.
- Top level contains: FSM, chunk index counter, operand/carry/working-sum registers, and output registers.

## Test plan
- WIDTH=8, CHUNK=1: a=8'hFF, b=8'h01, cin=0 → `done` 8 cycles after start; sum=8'h00, cout=1, ovf=0; busy high exactly 8 cycles.
- WIDTH=8, CHUNK=1: a=8'h7F, b=8'h01, cin=0 → sum=8'h80, cout=0, ovf=1. Then a=8'h80, b=8'h80 → sum=8'h00, cout=1, ovf=1.
- WIDTH=8, CHUNK=4: a=8'h3C, b=8'hC4, cin=1 → `done` 2 cycles after start; sum=8'h01, cout=1, ovf=0.
- Pulse start with a=8'h10, b=8'h20, then pulse start again 3 cycles later with a=8'hFF, b=8'hFF → single done, with sum=8'h30. `sum` holds its previous value until done.
- rst_n low for one cycle during cycle 3 of RUN → no done, all outputs 0. Next operation, a=8'h05, b=8'h03 → sum=8'h08.
- Exhaustive random/all-pairs for WIDTH=8 and CHUNK ∈ {1,2,4,8} with start held high → each done carries {cout,sum}=a+b+cin, correct ovf, and done period N+1.
